// File: rtl/input_debouncer.sv
// input_debouncer: per-channel 2-flop synchronizer plus 4-state debounce FSM.
// Define DEBOUNCE_EDGE_PULSE_EN to build the registered rise/fall pulses.
module input_debouncer #(
  parameter int WIDTH        = 2,
  parameter int CNT_W        = 16,
  parameter int STABLE_COUNT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic             s1_q;
    logic             s2_q;
    logic             lvl_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic             rise_q;
    logic             fall_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        lvl_q   <= 1'b0;
        state_q <= IDLE_LO;
        cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
`endif
      end else begin
        s1_q <= d[i];
        s2_q <= s1_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
        rise_q <= 1'b0;
        fall_q <= 1'b0;
`endif
        unique case (state_q)
          IDLE_LO: begin
            if (s2_q) begin
              state_q <= WAIT_HI;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
            end
          end
          WAIT_HI: begin
            if (!s2_q) begin
              state_q <= IDLE_LO;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE_HI;
              lvl_q   <= 1'b1;
              cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
              rise_q  <= 1'b1;
`endif
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end
          IDLE_HI: begin
            if (!s2_q) begin
              state_q <= WAIT_LO;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
            end
          end
          WAIT_LO: begin
            if (s2_q) begin
              state_q <= IDLE_HI;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE_LO;
              lvl_q   <= 1'b0;
              cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
              fall_q  <= 1'b1;
`endif
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end
        endcase
      end
    end

    assign q[i] = lvl_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
`endif
  end

`ifndef DEBOUNCE_EDGE_PULSE_EN
  // Pulse outputs are constant when edge detection is not built.
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
